// File: rtl/fpnew_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpnew_pkg
// Description : Shared FP datapath types: rounding modes, rounding status and
//               the per-lane round-up decision.
// Revision    : 1.0 - initial release
// ============================================================================
package fpnew_pkg;

    localparam logic DONT_CARE = 1'b1;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100,
        ROD = 3'b101,
        DYN = 3'b111
    } roundmode_e;

    typedef struct packed {
        logic exact_zero;
        logic inexact;
        logic carry;
    } rnd_status_t;

    // Unlisted encodings (including DYN) fall back to truncation.
    function automatic logic rnd_round_up(roundmode_e mode, logic lsb,
                                          logic [1:0] rs, logic sign);
        logic w_any;
        logic w_up;
        w_any = |rs;
        case (mode)
            RNE:     w_up = rs[1] & (rs[0] | lsb);
            RDN:     w_up = w_any & sign;
            RUP:     w_up = w_any & ~sign;
            RMM:     w_up = rs[1];
            ROD:     w_up = w_any & ~lsb;
            default: w_up = 1'b0;
        endcase
        return w_up;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fpnew_rounding_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : fpnew_rounding_pipe_if
// Description : Input/output handshake bundle of the rounding pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
interface fpnew_rounding_pipe_if
    import fpnew_pkg::*;
#(
    parameter int unsigned AbsWidth = 8,
    parameter int unsigned NumLanes = 2,
    parameter int unsigned TagWidth = 4
);
    logic                         in_valid_i;
    logic                         in_ready_o;
    logic [NumLanes*AbsWidth-1:0] abs_value_i;
    logic [NumLanes-1:0]          sign_i;
    logic [NumLanes*2-1:0]        round_sticky_bits_i;
    logic [NumLanes-1:0]          effective_subtraction_i;
    logic [NumLanes-1:0]          lane_mask_i;
    roundmode_e                   rnd_mode_i;
    logic [TagWidth-1:0]          tag_i;

    logic                         out_valid_o;
    logic                         out_ready_i;
    logic [NumLanes*AbsWidth-1:0] abs_rounded_o;
    logic [NumLanes-1:0]          sign_o;
    logic [NumLanes-1:0]          exact_zero_o;
    logic [NumLanes-1:0]          inexact_o;
    logic [NumLanes-1:0]          carry_o;
    logic [TagWidth-1:0]          tag_o;

    modport slave (
        input  in_valid_i, abs_value_i, sign_i, round_sticky_bits_i,
               effective_subtraction_i, lane_mask_i, rnd_mode_i, tag_i,
               out_ready_i,
        output in_ready_o, out_valid_o, abs_rounded_o, sign_o,
               exact_zero_o, inexact_o, carry_o, tag_o
    );

    modport master (
        output in_valid_i, abs_value_i, sign_i, round_sticky_bits_i,
               effective_subtraction_i, lane_mask_i, rnd_mode_i, tag_i,
               out_ready_i,
        input  in_ready_o, out_valid_o, abs_rounded_o, sign_o,
               exact_zero_o, inexact_o, carry_o, tag_o
    );
endinterface
`default_nettype wire

// File: rtl/fpnew_round_lane.sv
`default_nettype none
// ============================================================================
// Module      : fpnew_round_lane
// Description : Combinational rounding of one lane: decision, sum, sign, flags.
// Revision    : 1.0 - initial release
// ============================================================================
module fpnew_round_lane
    import fpnew_pkg::*;
#(
    parameter int unsigned AbsWidth = 8
) (
    input  logic [AbsWidth-1:0] abs_value_i,
    input  logic                sign_i,
    input  logic [1:0]          round_sticky_bits_i,
    input  logic                effective_subtraction_i,
    input  logic                lane_en_i,
    input  roundmode_e          rnd_mode_i,
    output logic [AbsWidth-1:0] abs_rounded_o,
    output logic                sign_o,
    output rnd_status_t         status_o
);
    logic              w_round_up;
    logic [AbsWidth:0] w_sum;
    logic              w_exact_zero;

    assign w_round_up   = rnd_round_up(rnd_mode_i, abs_value_i[0],
                                       round_sticky_bits_i, sign_i);
    // The extra MSB of the sum is the carry into the exponent.
    assign w_sum        = {1'b0, abs_value_i} + {{AbsWidth{1'b0}}, w_round_up};
    assign w_exact_zero = (abs_value_i == '0) && (round_sticky_bits_i == 2'b00);

    always_comb begin
        abs_rounded_o = '0;
        sign_o        = 1'b0;
        status_o      = '0;
        if (lane_en_i) begin
            abs_rounded_o       = w_sum[AbsWidth-1:0];
            // An exact zero from cancellation is -0 only when rounding down.
            sign_o              = (w_exact_zero && effective_subtraction_i)
                                  ? (rnd_mode_i == RDN) : sign_i;
            status_o.exact_zero = w_exact_zero;
            status_o.inexact    = |round_sticky_bits_i;
            status_o.carry      = w_sum[AbsWidth];
        end
    end
endmodule
`default_nettype wire

// File: rtl/fpnew_rounding_pipe.sv
`default_nettype none
// ============================================================================
// Module      : fpnew_rounding_pipe
// Description : Multi-lane rounding stage followed by NumPipeRegs elastic
//               register stages with valid/ready handshake and flush.
// Revision    : 1.0 - initial release
// ============================================================================
module fpnew_rounding_pipe
    import fpnew_pkg::*;
#(
    parameter int unsigned AbsWidth    = 8,
    parameter int unsigned NumLanes    = 2,
    parameter int unsigned NumPipeRegs = 2,
    parameter int unsigned TagWidth    = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    output logic                 busy_o,
    fpnew_rounding_pipe_if.slave pipe
);
    localparam int unsigned c_ABS_BITS = NumLanes * AbsWidth;
    localparam int unsigned c_DATA_W   = c_ABS_BITS + 4 * NumLanes + TagWidth;

    logic [c_ABS_BITS-1:0] w_abs_rounded;
    logic [NumLanes-1:0]   w_sign;
    logic [NumLanes-1:0]   w_zero;
    logic [NumLanes-1:0]   w_inexact;
    logic [NumLanes-1:0]   w_carry;

    for (genvar l = 0; l < NumLanes; l++) begin : g_lane
        rnd_status_t w_status;

        fpnew_round_lane #(
            .AbsWidth (AbsWidth)
        ) u_lane (
            .abs_value_i             (pipe.abs_value_i[l*AbsWidth +: AbsWidth]),
            .sign_i                  (pipe.sign_i[l]),
            .round_sticky_bits_i     (pipe.round_sticky_bits_i[2*l +: 2]),
            .effective_subtraction_i (pipe.effective_subtraction_i[l]),
            .lane_en_i               (pipe.lane_mask_i[l]),
            .rnd_mode_i              (pipe.rnd_mode_i),
            .abs_rounded_o           (w_abs_rounded[l*AbsWidth +: AbsWidth]),
            .sign_o                  (w_sign[l]),
            .status_o                (w_status)
        );

        assign w_zero[l]    = w_status.exact_zero;
        assign w_inexact[l] = w_status.inexact;
        assign w_carry[l]   = w_status.carry;
    end

    // Index 0 is the combinational input, index k the output of register k.
    logic [c_DATA_W-1:0]  w_stage_data [0:NumPipeRegs];
    logic [NumPipeRegs:0] w_stage_valid;
    logic [NumPipeRegs:0] w_stage_ready;

    assign w_stage_data[0]            = {pipe.tag_i, w_carry, w_inexact, w_zero,
                                         w_sign, w_abs_rounded};
    assign w_stage_valid[0]           = pipe.in_valid_i;
    assign w_stage_ready[NumPipeRegs] = pipe.out_ready_i;

    for (genvar i = 0; i < NumPipeRegs; i++) begin : g_stage
        logic                r_valid;
        logic [c_DATA_W-1:0] r_data;

        // Stage i can advance unless every downstream register is full and
        // the consumer stalls; this is the unrolled chain of stage readies.
        assign w_stage_ready[i] = pipe.out_ready_i
                                | ~(&w_stage_valid[NumPipeRegs:i+1]);

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_valid <= 1'b0;
                r_data  <= '0;
            end else begin
                if (flush_i) begin
                    r_valid <= 1'b0;
                end else if (w_stage_ready[i]) begin
                    r_valid <= w_stage_valid[i];
                end
                if (w_stage_ready[i]) begin
                    r_data <= w_stage_data[i];
                end
            end
        end

        assign w_stage_valid[i+1] = r_valid;
        assign w_stage_data[i+1]  = r_data;
    end

    if (NumPipeRegs > 0) begin : g_busy
        assign busy_o = |w_stage_valid[NumPipeRegs:1];
    end else begin : g_no_busy
        assign busy_o = 1'b0;
    end

    assign pipe.in_ready_o    = w_stage_ready[0] | (flush_i & (NumPipeRegs != 0));
    assign pipe.out_valid_o   = w_stage_valid[NumPipeRegs];
    assign pipe.abs_rounded_o = w_stage_data[NumPipeRegs][c_ABS_BITS-1:0];
    assign pipe.sign_o        = w_stage_data[NumPipeRegs][c_ABS_BITS +: NumLanes];
    assign pipe.exact_zero_o  = w_stage_data[NumPipeRegs][c_ABS_BITS + NumLanes +: NumLanes];
    assign pipe.inexact_o     = w_stage_data[NumPipeRegs][c_ABS_BITS + 2*NumLanes +: NumLanes];
    assign pipe.carry_o       = w_stage_data[NumPipeRegs][c_ABS_BITS + 3*NumLanes +: NumLanes];
    assign pipe.tag_o         = w_stage_data[NumPipeRegs][c_DATA_W-1 -: TagWidth];
endmodule
`default_nettype wire

// File: tb/tb_fpnew_rounding_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpnew_rounding_pipe
// Description : Self-checking bench: directed vector table, handshake corner
//               sequences and randomized traffic against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpnew_rounding_pipe;
    import fpnew_pkg::*;

    typedef struct packed {
        logic [15:0] abs;
        logic [1:0]  sign;
        logic [3:0]  rs;
        logic [1:0]  eff;
        logic [1:0]  mask;
        logic [2:0]  mode;
        logic [3:0]  tag;
    } item_t;

    typedef struct packed {
        logic [15:0] abs;
        logic [1:0]  sign;
        logic [1:0]  zero;
        logic [1:0]  inex;
        logic [1:0]  carry;
        logic [3:0]  tag;
    } res_t;

    typedef struct {
        item_t in;
        res_t  exp;
    } vec_t;

    logic clk;
    logic rst_n;
    logic flush;
    logic busy;
    int   checks = 0;
    int   errors = 0;

    fpnew_rounding_pipe_if #(.AbsWidth(8), .NumLanes(2), .TagWidth(4)) pif ();

    fpnew_rounding_pipe #(
        .AbsWidth    (8),
        .NumLanes    (2),
        .NumPipeRegs (2),
        .TagWidth    (4)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .flush_i (flush),
        .busy_o  (busy),
        .pipe    (pif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: rounding as the arithmetic rules state them, lane by lane.
    function automatic res_t model(item_t x);
        res_t r;
        r     = '0;
        r.tag = x.tag;
        for (int l = 0; l < 2; l++) begin
            int mag;
            int sum;
            bit rb, sb, sg, odd, inexact, up, zero;
            mag     = int'(x.abs[l*8 +: 8]);
            rb      = x.rs[2*l+1];
            sb      = x.rs[2*l];
            sg      = x.sign[l];
            odd     = (mag % 2) == 1;
            inexact = rb || sb;
            case (x.mode)
                3'd0:    up = !rb ? 1'b0 : (sb ? 1'b1 : odd);
                3'd2:    up = inexact && sg;
                3'd3:    up = inexact && !sg;
                3'd4:    up = rb;
                3'd5:    up = inexact && !odd;
                default: up = 1'b0;
            endcase
            sum  = mag + (up ? 1 : 0);
            zero = (mag == 0) && !inexact;
            if (x.mask[l]) begin
                r.abs[l*8 +: 8] = 8'(sum % 256);
                r.carry[l]      = sum > 255;
                r.zero[l]       = zero;
                r.inex[l]       = inexact;
                r.sign[l]       = (zero && x.eff[l]) ? (x.mode == 3'd2) : sg;
            end
        end
        return r;
    endfunction

    function automatic item_t rand_item(logic [3:0] tag);
        item_t x;
        for (int l = 0; l < 2; l++) begin
            case ($urandom_range(0, 5))
                0:       x.abs[l*8 +: 8] = 8'h00;
                1:       x.abs[l*8 +: 8] = 8'hFF;
                default: x.abs[l*8 +: 8] = 8'($urandom);
            endcase
        end
        x.sign = 2'($urandom);
        x.rs   = 4'($urandom);
        x.eff  = 2'($urandom);
        x.mask = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
        x.mode = 3'($urandom_range(0, 7));
        x.tag  = tag;
        return x;
    endfunction

    task automatic apply(item_t x);
        pif.abs_value_i             = x.abs;
        pif.sign_i                  = x.sign;
        pif.round_sticky_bits_i     = x.rs;
        pif.effective_subtraction_i = x.eff;
        pif.lane_mask_i             = x.mask;
        pif.rnd_mode_i              = roundmode_e'(x.mode);
        pif.tag_i                   = x.tag;
    endtask

    function automatic item_t cur_in();
        item_t x;
        x.abs  = pif.abs_value_i;
        x.sign = pif.sign_i;
        x.rs   = pif.round_sticky_bits_i;
        x.eff  = pif.effective_subtraction_i;
        x.mask = pif.lane_mask_i;
        x.mode = pif.rnd_mode_i;
        x.tag  = pif.tag_i;
        return x;
    endfunction

    function automatic res_t get_out();
        res_t r;
        r.abs   = pif.abs_rounded_o;
        r.sign  = pif.sign_o;
        r.zero  = pif.exact_zero_o;
        r.inex  = pif.inexact_o;
        r.carry = pif.carry_o;
        r.tag   = pif.tag_o;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: FIFO of model results, fed by input handshakes.
    res_t exp_q[$];
    int   in_cnt  = 0;
    int   out_cnt = 0;
    bit   sb_en   = 1'b0;
    bit   prev_hold = 1'b0;
    res_t prev_out;

    always @(negedge clk) begin
        if (sb_en && rst_n) begin
            if (prev_hold)
                check("out_stable", 64'({pif.out_valid_o, get_out()}), 64'({1'b1, prev_out}));
            if (pif.out_valid_o && pif.out_ready_i) begin
                out_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_out: got tag %h expected no item", pif.tag_o);
                end else begin
                    res_t e;
                    e = exp_q.pop_front();
                    check("out_item", 64'(get_out()), 64'(e));
                end
            end
            if (flush) begin
                exp_q.delete();
            end else if (pif.in_valid_i && pif.in_ready_o) begin
                exp_q.push_back(model(cur_in()));
                in_cnt++;
            end
            prev_hold = pif.out_valid_o && !pif.out_ready_i && !flush;
            prev_out  = get_out();
        end else begin
            prev_hold = 1'b0;
        end
    end

    vec_t vecs [12];

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base_in;
        int base_out;
        int seen;
        item_t it;

        //                 abs       sign   rs       eff    mask   mode    tag     abs      sign   zero   inex   carry  tag
        vecs[0]  = '{'{16'h0405, 2'b00, 4'b1010, 2'b00, 2'b11, 3'd0, 4'd0},  '{16'h0406, 2'b00, 2'b00, 2'b11, 2'b00, 4'd0}};
        vecs[1]  = '{'{16'h1010, 2'b11, 4'b0101, 2'b00, 2'b11, 3'd2, 4'd1},  '{16'h1111, 2'b11, 2'b00, 2'b11, 2'b00, 4'd1}};
        vecs[2]  = '{'{16'h1010, 2'b11, 4'b0101, 2'b00, 2'b11, 3'd3, 4'd2},  '{16'h1010, 2'b11, 2'b00, 2'b11, 2'b00, 4'd2}};
        vecs[3]  = '{'{16'h1110, 2'b11, 4'b0101, 2'b00, 2'b11, 3'd5, 4'd3},  '{16'h1111, 2'b11, 2'b00, 2'b11, 2'b00, 4'd3}};
        vecs[4]  = '{'{16'h0000, 2'b00, 4'b0000, 2'b11, 2'b11, 3'd2, 4'd4},  '{16'h0000, 2'b11, 2'b11, 2'b00, 2'b00, 4'd4}};
        vecs[5]  = '{'{16'h0000, 2'b00, 4'b0000, 2'b11, 2'b11, 3'd0, 4'd5},  '{16'h0000, 2'b00, 2'b11, 2'b00, 2'b00, 4'd5}};
        vecs[6]  = '{'{16'h7FFF, 2'b00, 4'b1011, 2'b00, 2'b11, 3'd0, 4'd6},  '{16'h8000, 2'b00, 2'b00, 2'b11, 2'b01, 4'd6}};
        vecs[7]  = '{'{16'hFF20, 2'b10, 4'b1101, 2'b00, 2'b01, 3'd3, 4'd7},  '{16'h0021, 2'b00, 2'b00, 2'b01, 2'b00, 4'd7}};
        vecs[8]  = '{'{16'h0303, 2'b00, 4'b0110, 2'b00, 2'b11, 3'd4, 4'd8},  '{16'h0304, 2'b00, 2'b00, 2'b11, 2'b00, 4'd8}};
        vecs[9]  = '{'{16'h0003, 2'b10, 4'b0011, 2'b10, 2'b11, 3'd6, 4'd9},  '{16'h0003, 2'b00, 2'b10, 2'b01, 2'b00, 4'd9}};
        vecs[10] = '{'{16'h80FF, 2'b01, 4'b1111, 2'b00, 2'b11, 3'd1, 4'd10}, '{16'h80FF, 2'b01, 2'b00, 2'b11, 2'b00, 4'd10}};
        vecs[11] = '{'{16'h00FF, 2'b01, 4'b0001, 2'b00, 2'b11, 3'd2, 4'd11}, '{16'h0000, 2'b01, 2'b10, 2'b01, 2'b01, 4'd11}};

        rst_n           = 1'b0;
        flush           = 1'b0;
        pif.in_valid_i  = 1'b0;
        pif.out_ready_i = 1'b1;
        apply('0);

        #3;
        check("rst_in_ready", 64'(pif.in_ready_o), 64'(1));
        check("rst_out_valid", 64'(pif.out_valid_o), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_data", 64'(get_out()), 64'(0));
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        step();
        check("post_rst_in_ready", 64'(pif.in_ready_o), 64'(1));

        // Directed table, one item at a time with full-latency checks.
        for (int v = 0; v < 12; v++) begin
            apply(vecs[v].in);
            pif.in_valid_i = 1'b1;
            step();
            pif.in_valid_i = 1'b0;
            check($sformatf("vec%0d_early", v), 64'(pif.out_valid_o), 64'(0));
            step();
            check($sformatf("vec%0d_valid", v), 64'(pif.out_valid_o), 64'(1));
            check($sformatf("vec%0d_data", v), 64'(get_out()), 64'(vecs[v].exp));
            step();
        end

        // Backpressure: six cycles of stall while tags are offered.
        sb_en           = 1'b1;
        base_in         = in_cnt;
        base_out        = out_cnt;
        pif.out_ready_i = 1'b0;
        for (int c = 0; c < 6; c++) begin
            apply(rand_item(4'(in_cnt - base_in)));
            pif.in_valid_i = 1'b1;
            step();
        end
        #1;
        check("bp_accepted", 64'(in_cnt - base_in), 64'(2));
        check("bp_in_ready", 64'(pif.in_ready_o), 64'(0));
        pif.out_ready_i = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (in_cnt - base_in < 6) begin
                apply(rand_item(4'(in_cnt - base_in)));
                pif.in_valid_i = 1'b1;
            end else begin
                pif.in_valid_i = 1'b0;
            end
            step();
        end
        pif.in_valid_i = 1'b0;
        check("bp_one_per_cycle", 64'(out_cnt - base_out), 64'(6));
        repeat (3) step();
        check("bp_drained", 64'(exp_q.size()), 64'(0));
        sb_en = 1'b0;

        // Flush with two items in flight and a third offered.
        pif.out_ready_i = 1'b0;
        apply(rand_item(4'd1));
        pif.in_valid_i = 1'b1;
        step();
        apply(rand_item(4'd2));
        step();
        apply(rand_item(4'd3));
        flush = 1'b1;
        #1;
        check("flush_in_ready", 64'(pif.in_ready_o), 64'(1));
        step();
        flush          = 1'b0;
        pif.in_valid_i = 1'b0;
        check("flush_out_valid", 64'(pif.out_valid_o), 64'(0));
        check("flush_busy", 64'(busy), 64'(0));
        pif.out_ready_i = 1'b1;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (pif.out_valid_o) seen++;
        end
        check("flush_no_out", 64'(seen), 64'(0));

        // Lane mask held at the output, then asynchronous reset mid-flight.
        pif.out_ready_i = 1'b0;
        it = '{16'hFF12, 2'b10, 4'b1100, 2'b00, 2'b01, 3'd1, 4'd9};
        apply(it);
        pif.in_valid_i = 1'b1;
        step();
        pif.in_valid_i = 1'b0;
        step();
        check("mask_valid", 64'(pif.out_valid_o), 64'(1));
        check("mask_data", 64'(get_out()), 64'({16'h0012, 2'b00, 2'b00, 2'b00, 2'b00, 4'd9}));
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(pif.out_valid_o), 64'(0));
        check("arst_busy", 64'(busy), 64'(0));
        check("arst_data", 64'(get_out()), 64'(0));
        check("arst_in_ready", 64'(pif.in_ready_o), 64'(1));
        @(negedge clk);
        rst_n           = 1'b1;
        pif.out_ready_i = 1'b1;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (pif.out_valid_o) seen++;
        end
        check("arst_no_out", 64'(seen), 64'(0));

        // Randomized traffic with stalls and occasional flushes.
        sb_en    = 1'b1;
        base_out = out_cnt;
        for (int c = 0; c < 400; c++) begin
            apply(rand_item(4'($urandom)));
            pif.in_valid_i  = ($urandom_range(0, 3) != 0);
            pif.out_ready_i = ($urandom_range(0, 3) != 0);
            flush           = ($urandom_range(0, 40) == 0);
            step();
        end
        flush           = 1'b0;
        pif.in_valid_i  = 1'b0;
        pif.out_ready_i = 1'b1;
        for (int c = 0; c < 20 && (exp_q.size() != 0 || busy); c++) step();
        check("rand_drained", 64'(exp_q.size()), 64'(0));
        check("rand_idle", 64'({busy, pif.out_valid_o}), 64'(0));
        check("rand_progress", 64'(out_cnt - base_out > 50), 64'(1));
        sb_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
